mdu_iter: RTL

- Parametrised, iterative multiply/divide unit implementing the RV M extension (RV32M, plus RV64M W-forms when XLEN=64).
- Sits beside the single-cycle ALU in the execute stage and takes the same operand bus.
- Multi-cycle, with a valid/ready handshake on both sides, a flush input, and a destination-tag pass-through so writeback can retire the result.

---
 rtl/mdu_iter_pkg.sv | 49 ++++
 rtl/mdu_iter_if.sv | 30 +++
 rtl/mdu_div_step.sv | 24 ++
 rtl/mdu_iter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - op encoding, FSM states and decode helpers for the iterative mul/div unit
package mdu_iter_pkg;

    localparam int MDU_OPW = 13;

    localparam int MDU_OP_MUL    = 0;
    localparam int MDU_OP_MULH   = 1;
    localparam int MDU_OP_MULHSU = 2;
    localparam int MDU_OP_MULHU  = 3;
    localparam int MDU_OP_DIV    = 4;
    localparam int MDU_OP_DIVU   = 5;
    localparam int MDU_OP_REM    = 6;
    localparam int MDU_OP_REMU   = 7;
    localparam int MDU_OP_MULW   = 8;
    localparam int MDU_OP_DIVW   = 9;
    localparam int MDU_OP_DIVUW  = 10;
    localparam int MDU_OP_REMW   = 11;
    localparam int MDU_OP_REMUW  = 12;

    typedef logic [MDU_OPW-1:0] mdu_op_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam mdu_op_t OP_BIT = mdu_op_t'(1);

    localparam mdu_op_t OPS_MUL = (OP_BIT << MDU_OP_MUL) | (OP_BIT << MDU_OP_MULH)
                                | (OP_BIT << MDU_OP_MULHSU) | (OP_BIT << MDU_OP_MULHU)
                                | (OP_BIT << MDU_OP_MULW);
    localparam mdu_op_t OPS_HI  = (OP_BIT << MDU_OP_MULH) | (OP_BIT << MDU_OP_MULHSU)
                                | (OP_BIT << MDU_OP_MULHU);
    localparam mdu_op_t OPS_REM = (OP_BIT << MDU_OP_REM) | (OP_BIT << MDU_OP_REMU)
                                | (OP_BIT << MDU_OP_REMW) | (OP_BIT << MDU_OP_REMUW);
    localparam mdu_op_t OPS_W   = (OP_BIT << MDU_OP_MULW) | (OP_BIT << MDU_OP_DIVW)
                                | (OP_BIT << MDU_OP_DIVUW) | (OP_BIT << MDU_OP_REMW)
                                | (OP_BIT << MDU_OP_REMUW);
    // Operand 1 is signed for these; operand 2 additionally excludes MULHSU.
    localparam mdu_op_t OPS_S2  = (OP_BIT << MDU_OP_MULH) | (OP_BIT << MDU_OP_DIV)
                                | (OP_BIT << MDU_OP_REM) | (OP_BIT << MDU_OP_DIVW)
                                | (OP_BIT << MDU_OP_REMW);
    localparam mdu_op_t OPS_S1  = OPS_S2 | (OP_BIT << MDU_OP_MULHSU);

    function automatic logic is_onehot(input mdu_op_t v);
        return (v != '0) && ((v & (v - OP_BIT)) == '0);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/response handshake bundle between issue logic and the mul/div unit
interface mdu_iter_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    import mdu_iter_pkg::*;

    logic              i_valid;
    logic              o_ready;
    mdu_op_t           i_fu_sel;
    logic [XLEN-1:0]   i_operand1;
    logic [XLEN-1:0]   i_operand2;
    logic [TAG_W-1:0]  i_tag;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [XLEN-1:0]   o_result;
    logic [TAG_W-1:0]  o_tag;

    modport master (
        output i_valid, i_fu_sel, i_operand1, i_operand2, i_tag, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_tag
    );

    modport slave (
        input  i_valid, i_fu_sel, i_operand1, i_operand2, i_tag, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_tag
    );

endinterface

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division iteration
module mdu_div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_in,
    input  logic         dividend_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W-1:0] rem_sub;

    always_comb begin
        shifted = {rem_in, dividend_msb};
        // A set carry-out bit already exceeds any W-bit divisor, and the true
        // difference is below the divisor, so a W-bit wrapping subtract is exact.
        q_bit   = shifted[W] | (shifted[W-1:0] >= divisor);
        rem_sub = shifted[W-1:0] - divisor;
        rem_out = q_bit ? rem_sub : shifted[W-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV M-extension multiply/divide unit with tag pass-through
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 2,
    parameter int TAG_W    = 5
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int PW    = XLEN + MUL_BITS;

    localparam logic [CNT_W-1:0] N_MUL  = CNT_W'(XLEN / MUL_BITS);
    localparam logic [CNT_W-1:0] N_MULW = CNT_W'(32 / MUL_BITS);
    localparam logic [CNT_W-1:0] N_DIV  = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] N_DIVW = CNT_W'(32);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  tag_out;
    logic              op_mul;
    logic              op_hi;
    logic              op_w;
    logic              op_rem;
    logic              neg_res;
    logic              neg_rem;

    logic              sel_ok;
    logic              w_sel;
    logic              w_op;
    logic              d_nop;
    logic              d_mul;
    logic              d_hi;
    logic              d_rem;
    logic              d_s1;
    logic              d_s2;
    logic              d_neg1;
    logic              d_neg2;
    logic              d_div0;
    logic              d_ovf;
    logic              d_special;
    logic [XLEN-1:0]   wmask;
    logic [XLEN-1:0]   msb_w;
    logic [XLEN-1:0]   a1;
    logic [XLEN-1:0]   a2;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN-1:0]   spec_val;

    always_comb begin
        sel_ok = is_onehot(bus.i_fu_sel);
        w_sel  = |(bus.i_fu_sel & OPS_W);
        w_op   = w_sel && (XLEN == 64);
        d_nop  = w_sel && (XLEN != 64);
        d_mul  = |(bus.i_fu_sel & OPS_MUL);
        d_hi   = |(bus.i_fu_sel & OPS_HI);
        d_rem  = |(bus.i_fu_sel & OPS_REM);
        d_s1   = |(bus.i_fu_sel & OPS_S1);
        d_s2   = |(bus.i_fu_sel & OPS_S2);

        // W-forms operate on the low word; the mask also bounds the magnitudes.
        wmask  = w_op ? XLEN'(32'hFFFF_FFFF) : '1;
        msb_w  = w_op ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        a1     = bus.i_operand1 & wmask;
        a2     = bus.i_operand2 & wmask;
        d_neg1 = d_s1 && (w_op ? bus.i_operand1[31] : bus.i_operand1[XLEN-1]);
        d_neg2 = d_s2 && (w_op ? bus.i_operand2[31] : bus.i_operand2[XLEN-1]);
        mag1   = (d_neg1 ? -bus.i_operand1 : bus.i_operand1) & wmask;
        mag2   = (d_neg2 ? -bus.i_operand2 : bus.i_operand2) & wmask;

        d_div0    = !d_mul && (a2 == '0);
        d_ovf     = !d_mul && d_s2 && (a1 == msb_w) && (a2 == wmask);
        d_special = d_nop || d_div0 || d_ovf;

        if (d_div0) begin
            spec_val = d_rem ? bus.i_operand1 : '1;
        end else begin
            spec_val = d_rem ? '0 : bus.i_operand1;
        end
        if (d_nop) begin
            spec_val = '0;
        end
    end

    // Multiplier: add opnd * low digit into the upper half, then shift the
    // whole accumulator right by one digit.
    logic [PW-1:0]     partial;
    logic [PW-1:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    always_comb begin
        partial  = PW'(opnd) * PW'(acc[MUL_BITS-1:0]);
        mul_sum  = PW'(acc[2*XLEN-1:XLEN]) + partial;
        mul_next = {mul_sum, acc[XLEN-1:MUL_BITS]};
    end

    logic [XLEN-1:0]   rem_next;
    logic              q_bit;
    logic [2*XLEN-1:0] div_next;

    mdu_div_step #(
        .W (XLEN)
    ) u_div_step (
        .rem_in       (acc[2*XLEN-1:XLEN]),
        .dividend_msb (acc[XLEN-1]),
        .divisor      (opnd),
        .rem_out      (rem_next),
        .q_bit        (q_bit)
    );

    assign div_next = {rem_next, acc[XLEN-2:0], q_bit};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rmd;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        // A W-form product ends up 32 bits below the top of the low half.
        if (op_mul) begin
            if (op_hi) begin
                raw = prod[2*XLEN-1:XLEN];
            end else if (op_w) begin
                raw = XLEN'(prod[XLEN-1:XLEN-32]);
            end else begin
                raw = prod[XLEN-1:0];
            end
        end else begin
            raw = op_rem ? rmd : quo;
        end
        fix_val = op_w ? XLEN'($signed(raw[31:0])) : raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            opnd     <= '0;
            acc      <= '0;
            tag_q    <= '0;
            result_q <= '0;
            tag_out  <= '0;
            op_mul   <= 1'b0;
            op_hi    <= 1'b0;
            op_w     <= 1'b0;
            op_rem   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (bus.i_flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_valid && sel_ok) begin
                        tag_q <= bus.i_tag;
                        op_hi <= d_hi;
                        op_w  <= w_op;
                        if (d_special) begin
                            // The precomputed answer rides through FIX as a plain quotient.
                            op_mul  <= 1'b0;
                            op_rem  <= 1'b0;
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                            acc     <= {{XLEN{1'b0}}, spec_val};
                            state   <= S_FIX;
                        end else begin
                            op_mul  <= d_mul;
                            op_rem  <= d_rem;
                            neg_res <= d_neg1 ^ d_neg2;
                            neg_rem <= d_neg1;
                            if (d_mul) begin
                                opnd <= mag1;
                                acc  <= {{XLEN{1'b0}}, mag2};
                                cnt  <= w_op ? N_MULW : N_MUL;
                            end else begin
                                opnd <= mag2;
                                acc  <= {{XLEN{1'b0}}, (w_op ? (mag1 << (XLEN - 32)) : mag1)};
                                cnt  <= w_op ? N_DIVW : N_DIV;
                            end
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc <= op_mul ? mul_next : div_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_val;
                    tag_out  <= tag_q;
                    state    <= S_DONE;
                end
                default: begin
                    if (bus.i_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.o_ready  = (state == S_IDLE);
    assign bus.o_valid  = (state == S_DONE);
    assign bus.o_result = result_q;
    assign bus.o_tag    = tag_out;

endmodule
